multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter MUL_LATENCY, default 3: cycles from MUL issue to writeback; legal range 2..15.
REQ-002 Parameter ENABLE_MUL, default 1: 1 decodes RV32M MUL as multicycle; 0 decodes it as a plain R-type op.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and arst.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 arst  in  1  asynchronous active-high reset.
REQ-006 instr_valid  in  1  decode-stage instruction present.
REQ-007 opcode  in  7  instr[6:0].
REQ-008 funct7  in  7  instr[31:25].
REQ-009 flush  in  1  squash the current decode and any multiply in progress.
REQ-010 alu_op  out  2  00 ADD, 01 SUB, 10 R-type.
REQ-011 alu_src, mem_2_reg, mem_read, mem_write, branch, jump, reg_write  out  1 each  datapath controls.
REQ-012 mul_start  out  1  one-cycle pulse that launches the multiplier.
REQ-013 mul_sel  out  1  writeback selects the multiplier result.
REQ-014 stall  out  1  holds the upstream pipeline (PC, IF/ID).
REQ-015 ctrl_valid  out  1  the control outputs describe a committing instruction.
REQ-016 illegal  out  1  unsupported opcode accepted.

Function
REQ-017 All outputs except stall SHALL be registered, with a latency of 1 cycle from an accepted decode.
REQ-018 stall SHALL be driven directly by state and SHALL be 1 exactly when the state is MUL_BUSY.
REQ-019 Decode, for an accepted non-MUL opcode:
- R (0110011): alu_op=10, reg_write=1.
- I (0010011): alu_src=1, reg_write=1, alu_op=00.
- LOAD (0000011): alu_src=1, mem_2_reg=1, mem_read=1, reg_write=1, alu_op=00.
- STORE (0100011): alu_src=1, mem_write=1, alu_op=00.
- BEQ (1100011): branch=1, alu_op=01.
- JAL (1101111): jump=1, alu_op=10.
- All other controls are 0, and ctrl_valid=1.
REQ-020 MUL is opcode 0110011 with funct7=0000001 and ENABLE_MUL=1.
REQ-021 Other opcodes: all controls 0 (NOP), ctrl_valid=0, illegal=1 for one cycle.
REQ-022 The FSM SHALL have two states, IDLE and MUL_BUSY, plus a down-counter cnt of 4 bits.
REQ-023 IDLE, instr_valid=1, MUL decoded, flush=0:
- Next edge: state to MUL_BUSY, cnt loaded with MUL_LATENCY-1.
- Outputs: mul_start=1, alu_op=10, reg_write=0, ctrl_valid=0.
REQ-024 MUL_BUSY with cnt>1: decrement cnt; outputs NOP; instr_valid and opcode are ignored.
REQ-025 MUL_BUSY with cnt==1:
- Next edge: state to IDLE.
- Outputs: reg_write=1, mul_sel=1, alu_op=10, ctrl_valid=1 for exactly one cycle.
REQ-026 stall SHALL be high for exactly MUL_LATENCY-1 consecutive cycles per MUL.
REQ-027 In IDLE, a new instruction SHALL be accepted in the writeback cycle, so MULs can be issued back to back.
REQ-028 instr_valid=0 in IDLE SHALL give NOP outputs with ctrl_valid=0 and illegal=0.
REQ-029 flush=1 SHALL take priority over instr_valid in any state.
REQ-030 On flush, the next edge gives NOP outputs, state IDLE, cnt=0, and no mul_sel or reg_write writeback.
REQ-031 flush arriving on the cnt==1 cycle SHALL also suppress the writeback.
REQ-032 ENABLE_MUL=0 SHALL decode funct7=0000001 as a plain R-type op, with no stall and no mul_start.
REQ-033 mul_start, mul_sel and illegal SHALL never be high for two consecutive cycles.

Reset
REQ-034 While arst=1, and immediately on assertion regardless of clk, the block SHALL hold the following reset state:
- state=IDLE, cnt=0.
- All outputs 0, including stall.
REQ-035 Deassertion SHALL be followed by normal operation from the first rising edge.
REQ-036 arst asserted mid-MUL SHALL abort it with no writeback.

Verification
REQ-037 The bench SHALL cover each opcode of REQ-019 (one per cycle): each gives its REQ-019 control vector the next cycle with ctrl_valid=1; alu_op for BEQ is 01, for LOAD is 00.
REQ-038 The bench SHALL cover MUL with MUL_LATENCY=3:
- Stimulus: MUL in at cycle 0.
- Cycle 1: mul_start=1.
- Cycles 1–2: stall=1.
- Cycle 3: reg_write=1, mul_sel=1, ctrl_valid=1.
REQ-039 The bench SHALL cover MUL_LATENCY=5 back-to-back MULs: stall high for 4 cycles each, two writeback pulses 5 cycles apart.
REQ-040 The bench SHALL cover flush during MUL_BUSY (cnt=2), and separately flush on the cnt==1 cycle: the next cycle gives state IDLE, stall=0, and no writeback.
REQ-041 The bench SHALL cover opcode 1111111 valid: the next cycle gives illegal=1 and all controls 0; the cycle after gives illegal=0.
REQ-042 The bench SHALL cover arst pulsed asynchronously mid-MUL: stall and all outputs go to 0 immediately, and no writeback follows.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Decode-stage control unit with a multicycle RV32M MUL sequencer.
// Control outputs are registered; stall comes straight from the FSM state.
module multicycle_control_unit #(
   parameter int MUL_LATENCY = 3,
   parameter bit ENABLE_MUL  = 1'b1
) (
   input  logic       clk,
   input  logic       arst,
   input  logic       instr_valid,
   input  logic [6:0] opcode,
   input  logic [6:0] funct7,
   input  logic       flush,
   output logic [1:0] alu_op,
   output logic       alu_src,
   output logic       mem_2_reg,
   output logic       mem_read,
   output logic       mem_write,
   output logic       branch,
   output logic       jump,
   output logic       reg_write,
   output logic       mul_start,
   output logic       mul_sel,
   output logic       stall,
   output logic       ctrl_valid,
   output logic       illegal
);

   typedef enum logic {IDLE, MUL_BUSY} state_t;

   typedef struct packed {
      logic [1:0] alu_op;
      logic       alu_src;
      logic       mem_2_reg;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic       reg_write;
      logic       mul_start;
      logic       mul_sel;
      logic       ctrl_valid;
      logic       illegal;
   } ctrl_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] F7_MUL   = 7'b0000001;
   localparam logic [3:0] CNT_LOAD = 4'(MUL_LATENCY - 1);

   state_t     state, state_n;
   logic [3:0] cnt, cnt_n;
   ctrl_t      ctrl_q, ctrl_n;
   logic       is_mul;

   assign is_mul = ENABLE_MUL && (opcode == OP_R) && (funct7 == F7_MUL);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state  <= IDLE;
         cnt    <= '0;
         ctrl_q <= '0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         ctrl_q <= ctrl_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ctrl_n  = '0;
      if (flush) begin
         state_n = IDLE;
         cnt_n   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (instr_valid && is_mul) begin
                  state_n          = MUL_BUSY;
                  cnt_n            = CNT_LOAD;
                  ctrl_n.mul_start = 1'b1;
                  ctrl_n.alu_op    = 2'b10;
               end else if (instr_valid) begin
                  ctrl_n.ctrl_valid = 1'b1;
                  unique case (1'b1)
                     (opcode == OP_R): begin
                        ctrl_n.alu_op    = 2'b10;
                        ctrl_n.reg_write = 1'b1;
                     end
                     (opcode == OP_I): begin
                        ctrl_n.alu_src   = 1'b1;
                        ctrl_n.reg_write = 1'b1;
                     end
                     (opcode == OP_LOAD): begin
                        ctrl_n.alu_src   = 1'b1;
                        ctrl_n.mem_2_reg = 1'b1;
                        ctrl_n.mem_read  = 1'b1;
                        ctrl_n.reg_write = 1'b1;
                     end
                     (opcode == OP_STORE): begin
                        ctrl_n.alu_src   = 1'b1;
                        ctrl_n.mem_write = 1'b1;
                     end
                     (opcode == OP_BEQ): begin
                        ctrl_n.branch = 1'b1;
                        ctrl_n.alu_op = 2'b01;
                     end
                     (opcode == OP_JAL): begin
                        ctrl_n.jump   = 1'b1;
                        ctrl_n.alu_op = 2'b10;
                     end
                     default: begin
                        // back-to-back bad opcodes must not stretch the pulse
                        ctrl_n.ctrl_valid = 1'b0;
                        ctrl_n.illegal    = ~ctrl_q.illegal;
                     end
                  endcase
               end
            end
            MUL_BUSY: begin
               if (cnt > 4'd1) begin
                  cnt_n = cnt - 4'd1;
               end else begin
                  state_n           = IDLE;
                  cnt_n             = '0;
                  ctrl_n.alu_op     = 2'b10;
                  ctrl_n.reg_write  = 1'b1;
                  ctrl_n.mul_sel    = 1'b1;
                  ctrl_n.ctrl_valid = 1'b1;
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         endcase
      end
   end

   assign alu_op     = ctrl_q.alu_op;
   assign alu_src    = ctrl_q.alu_src;
   assign mem_2_reg  = ctrl_q.mem_2_reg;
   assign mem_read   = ctrl_q.mem_read;
   assign mem_write  = ctrl_q.mem_write;
   assign branch     = ctrl_q.branch;
   assign jump       = ctrl_q.jump;
   assign reg_write  = ctrl_q.reg_write;
   assign mul_start  = ctrl_q.mul_start;
   assign mul_sel    = ctrl_q.mul_sel;
   assign ctrl_valid = ctrl_q.ctrl_valid;
   assign illegal    = ctrl_q.illegal;
   assign stall      = (state == MUL_BUSY);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: three instances (L=3, L=5, MUL disabled) share stimulus.
module tb_multicycle_control_unit;

   logic       clk = 1'b0;
   logic       arst;
   logic       instr_valid;
   logic [6:0] opcode;
   logic [6:0] funct7;
   logic       flush;

   logic [1:0] alu_op [3];
   logic       alu_src [3], mem_2_reg [3], mem_read [3], mem_write [3];
   logic       branch [3], jump [3], reg_write [3], mul_start [3];
   logic       mul_sel [3], stall [3], ctrl_valid [3], illegal [3];
   logic [12:0] cv [3];

   int total = 0;
   int fails = 0;

   always #5 clk = ~clk;

   multicycle_control_unit #(.MUL_LATENCY(3), .ENABLE_MUL(1'b1)) u0 (
      .clk(clk), .arst(arst), .instr_valid(instr_valid),
      .opcode(opcode), .funct7(funct7), .flush(flush),
      .alu_op(alu_op[0]), .alu_src(alu_src[0]), .mem_2_reg(mem_2_reg[0]),
      .mem_read(mem_read[0]), .mem_write(mem_write[0]),
      .branch(branch[0]), .jump(jump[0]), .reg_write(reg_write[0]),
      .mul_start(mul_start[0]), .mul_sel(mul_sel[0]), .stall(stall[0]),
      .ctrl_valid(ctrl_valid[0]), .illegal(illegal[0]));

   multicycle_control_unit #(.MUL_LATENCY(5), .ENABLE_MUL(1'b1)) u1 (
      .clk(clk), .arst(arst), .instr_valid(instr_valid),
      .opcode(opcode), .funct7(funct7), .flush(flush),
      .alu_op(alu_op[1]), .alu_src(alu_src[1]), .mem_2_reg(mem_2_reg[1]),
      .mem_read(mem_read[1]), .mem_write(mem_write[1]),
      .branch(branch[1]), .jump(jump[1]), .reg_write(reg_write[1]),
      .mul_start(mul_start[1]), .mul_sel(mul_sel[1]), .stall(stall[1]),
      .ctrl_valid(ctrl_valid[1]), .illegal(illegal[1]));

   multicycle_control_unit #(.MUL_LATENCY(3), .ENABLE_MUL(1'b0)) u2 (
      .clk(clk), .arst(arst), .instr_valid(instr_valid),
      .opcode(opcode), .funct7(funct7), .flush(flush),
      .alu_op(alu_op[2]), .alu_src(alu_src[2]), .mem_2_reg(mem_2_reg[2]),
      .mem_read(mem_read[2]), .mem_write(mem_write[2]),
      .branch(branch[2]), .jump(jump[2]), .reg_write(reg_write[2]),
      .mul_start(mul_start[2]), .mul_sel(mul_sel[2]), .stall(stall[2]),
      .ctrl_valid(ctrl_valid[2]), .illegal(illegal[2]));

   always_comb begin
      for (int i = 0; i < 3; i++)
         cv[i] = {alu_op[i], alu_src[i], mem_2_reg[i], mem_read[i],
                  mem_write[i], branch[i], jump[i], reg_write[i],
                  mul_start[i], mul_sel[i], ctrl_valid[i], illegal[i]};
   end

   // field order: alu_op src m2r mrd mwr br j rw mstart msel cvalid ill
   function automatic logic [12:0] mk(
      input logic [1:0] op, input logic src, input logic m2r,
      input logic mrd, input logic mwr, input logic br, input logic j,
      input logic rw, input logic ms, input logic msel,
      input logic cvl, input logic ill);
      return {op, src, m2r, mrd, mwr, br, j, rw, ms, msel, cvl, ill};
   endfunction

   localparam logic [12:0] NOP = 13'd0;

   task automatic chk(input string tag, input logic [12:0] obs,
                      input logic [12:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic v, input logic [6:0] op,
                      input logic [6:0] f7);
      instr_valid = v;
      opcode      = op;
      funct7      = f7;
   endtask

   task automatic pulse_rst();
      #2 arst = 1'b1;
      #2 arst = 1'b0;
   endtask

   localparam logic [6:0] R = 7'b0110011;
   localparam logic [6:0] M7 = 7'b0000001;

   initial begin
      arst = 1'b1;
      flush = 1'b0;
      put(1'b0, 7'd0, 7'd0);
      #2;
      chk("reset_cv0", cv[0], NOP);
      chk("reset_stall0", {12'd0, stall[0]}, 13'd0);
      chk("reset_cv1", cv[1], NOP);
      #1 arst = 1'b0;

      // one opcode per cycle
      put(1'b1, R, 7'd0);
      tick(); chk("r_type", cv[0], mk(2'b10,0,0,0,0,0,0,1,0,0,1,0));
      put(1'b1, 7'b0010011, 7'd0);
      tick(); chk("i_type", cv[0], mk(2'b00,1,0,0,0,0,0,1,0,0,1,0));
      put(1'b1, 7'b0000011, 7'd0);
      tick(); chk("load", cv[0], mk(2'b00,1,1,1,0,0,0,1,0,0,1,0));
      put(1'b1, 7'b0100011, 7'd0);
      tick(); chk("store", cv[0], mk(2'b00,1,0,0,1,0,0,0,0,0,1,0));
      put(1'b1, 7'b1100011, 7'd0);
      tick(); chk("beq", cv[0], mk(2'b01,0,0,0,0,1,0,0,0,0,1,0));
      put(1'b1, 7'b1101111, 7'd0);
      tick(); chk("jal", cv[0], mk(2'b10,0,0,0,0,0,1,0,0,0,1,0));
      put(1'b1, 7'b1111111, 7'd0);
      tick(); chk("illegal_1", cv[0], mk(2'b00,0,0,0,0,0,0,0,0,0,0,1));
      tick(); chk("illegal_2nd", cv[0], NOP);
      put(1'b0, 7'b1111111, 7'd0);
      tick(); chk("idle_nop", cv[0], NOP);

      // MUL, latency 3; disabled-MUL instance sees a plain R op
      pulse_rst();
      put(1'b1, R, M7);
      tick();
      chk("mul3_c1", cv[0], mk(2'b10,0,0,0,0,0,0,0,1,0,0,0));
      chk("mul3_c1_stall", {12'd0, stall[0]}, 13'd1);
      chk("nomul_r", cv[2], mk(2'b10,0,0,0,0,0,0,1,0,0,1,0));
      chk("nomul_stall", {12'd0, stall[2]}, 13'd0);
      put(1'b1, 7'b0010011, 7'd0);
      tick();
      chk("mul3_c2", cv[0], NOP);
      chk("mul3_c2_stall", {12'd0, stall[0]}, 13'd1);
      put(1'b0, 7'd0, 7'd0);
      tick();
      chk("mul3_wb", cv[0], mk(2'b10,0,0,0,0,0,0,1,0,1,1,0));
      chk("mul3_c3_stall", {12'd0, stall[0]}, 13'd0);
      tick(); chk("mul3_after", cv[0], NOP);

      // latency 5, back to back
      pulse_rst();
      put(1'b1, R, M7);
      for (int m = 0; m < 2; m++) begin
         tick();
         chk("mul5_start", cv[1], mk(2'b10,0,0,0,0,0,0,0,1,0,0,0));
         put(1'b0, 7'd0, 7'd0);
         for (int c = 0; c < 4; c++) begin
            chk("mul5_stall", {12'd0, stall[1]}, 13'd1);
            if (c < 3) begin
               tick();
               chk("mul5_busy_nop", cv[1], NOP);
            end
         end
         tick();
         chk("mul5_wb", cv[1], mk(2'b10,0,0,0,0,0,0,1,0,1,1,0));
         chk("mul5_wb_stall", {12'd0, stall[1]}, 13'd0);
         put(1'b1, R, M7);
      end
      put(1'b0, 7'd0, 7'd0);
      tick(); chk("mul5_end", cv[1], NOP);

      // flush while cnt==2
      pulse_rst();
      put(1'b1, R, M7);
      tick();
      chk("fl2_busy", {12'd0, stall[0]}, 13'd1);
      put(1'b0, 7'd0, 7'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl2_stall", {12'd0, stall[0]}, 13'd0);
      chk("fl2_nop", cv[0], NOP);
      tick(); chk("fl2_no_wb", cv[0], NOP);

      // flush on the cnt==1 cycle
      put(1'b1, R, M7);
      tick();
      put(1'b0, 7'd0, 7'd0);
      tick();
      chk("fl1_busy", {12'd0, stall[0]}, 13'd1);
      flush = 1'b1;
      tick();
      chk("fl1_no_wb", cv[0], NOP);
      chk("fl1_stall", {12'd0, stall[0]}, 13'd0);
      put(1'b1, R, 7'd0);
      tick();
      flush = 1'b0;
      chk("flush_prio", cv[0], NOP);
      put(1'b0, 7'd0, 7'd0);

      // async reset mid-MUL
      put(1'b1, R, M7);
      tick();
      put(1'b0, 7'd0, 7'd0);
      chk("ar_busy", {12'd0, stall[0]}, 13'd1);
      #2 arst = 1'b1;
      #1;
      chk("ar_stall", {12'd0, stall[0]}, 13'd0);
      chk("ar_cv", cv[0], NOP);
      #2 arst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("ar_no_wb", cv[0], NOP);
         chk("ar_no_stall", {12'd0, stall[0]}, 13'd0);
      end

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
